// File: rtl/shift_arbiter_if.sv
// Request/response bus of the two-requester shift unit.
//   req0_* / req1_* : valid/ready handshake carrying operand a, shift amount b and op code
//   rsp_*           : valid/ready result channel; rsp_id names the requester that issued it
// The master modport is the requester/consumer side; the slave modport is the shift unit.
interface shift_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [3:0]       req0_b;
  logic [1:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [3:0]       req1_b;
  logic [1:0]       req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbitrated barrel shifter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : shift_arbiter_if.slave (two request channels in, one response channel out)
//   busy  : high whenever an operation is in flight (state != IDLE)
// One operation at a time: IDLE accepts and latches the winner's operands, EXEC registers
// the shifted result, RESP holds it until the consumer takes it.
// RR_EN=1 alternates on contention; RR_EN=0 gives requester 0 fixed priority.

// Combinational shifter: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Only WIDTH=16 is supported.
module shift_arbiter_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [3:0]       b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = a;
    case (op)
      2'b00:   y = a << b;
      2'b01:   y = a >> b;
      2'b10:   y = $signed(a) >>> b;
      // a << WIDTH evaluates to zero in this 16-bit context, so b=0 yields a unchanged.
      default: y = (a >> b) | (a << (WIDTH - int'(b)));
    endcase
  end
endmodule

module shift_arbiter #(
  parameter int WIDTH = 16,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_arbiter_if.slave   bus,
  output logic             busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [3:0]       b;
    logic [1:0]       op;
    logic             id;
  } opr_t;

  state_t           state, state_nxt;
  opr_t             opr;
  logic             last_grant;
  logic             win;        // winning requester index this cycle
  logic             accept;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] data_q;
  logic             id_q;

  // Arbitration: a lone requester always wins; on contention round-robin picks the
  // requester that did not win last time, fixed priority picks requester 0.
  always_comb begin
    win = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      win = RR_EN ? ~last_grant : 1'b0;
  end

  assign accept         = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !win;
  assign bus.req1_ready = accept && win;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  shift_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (opr.a),
    .b  (opr.b),
    .op (opr.op),
    .y  (alu_y)
  );

  // Operands are captured only on accept, so requester activity during EXEC/RESP
  // cannot disturb the in-flight result; the result registers only move in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr        <= '0;
      last_grant <= 1'b1;
      data_q     <= '0;
      id_q       <= 1'b0;
    end else begin
      if (accept) begin
        opr.a      <= win ? bus.req1_a  : bus.req0_a;
        opr.b      <= win ? bus.req1_b  : bus.req0_b;
        opr.op     <= win ? bus.req1_op : bus.req0_op;
        opr.id     <= win;
        last_grant <= win;
      end
      if (state == EXEC) begin
        data_q <= alu_y;
        id_q   <= opr.id;
      end
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a round-robin instance (u_rr) and a fixed-priority instance
// (u_fp) see identical stimulus. Directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_a, busy_b;
  int   tests = 0;
  int   fails = 0;

  shift_arbiter_if #(.WIDTH(16)) ia ();
  shift_arbiter_if #(.WIDTH(16)) ib ();

  shift_arbiter #(.WIDTH(16), .RR_EN(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(ia), .busy(busy_a));
  shift_arbiter #(.WIDTH(16), .RR_EN(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(ib), .busy(busy_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  b;
    logic [1:0]  op;
    logic        id;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [15:0] a0, input logic [3:0] b0, input logic [1:0] op0,
                       input logic v1, input logic [15:0] a1, input logic [3:0] b1, input logic [1:0] op1);
    ia.req0_valid = v0; ia.req0_a = a0; ia.req0_b = b0; ia.req0_op = op0;
    ia.req1_valid = v1; ia.req1_a = a1; ia.req1_b = b1; ia.req1_op = op1;
    ib.req0_valid = v0; ib.req0_a = a0; ib.req0_b = b0; ib.req0_op = op0;
    ib.req1_valid = v1; ib.req1_a = a1; ib.req1_b = b1; ib.req1_op = op1;
  endtask

  task automatic set_ready(input logic r);
    ia.rsp_ready = r;
    ib.rsp_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b0, 16'h0, 4'h0, 2'b00);
    set_ready(1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference shifter from plain arithmetic: multiply/divide by 2**b, floor division for
  // the arithmetic shift, and single-bit rotation repeated b times.
  function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [3:0] b, input logic [1:0] op);
    int p, s, r;
    p = 1 << b;
    case (op)
      2'b00: r = (int'(a) * p) % 65536;
      2'b01: r = int'(a) / p;
      2'b10: begin
        s = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        r = (s >= 0) ? s / p : -((-s + p - 1) / p);
        r = r & 32'h0000FFFF;
      end
      default: begin
        r = int'(a);
        repeat (b) r = (r / 2) + (r % 2) * 32768;
      end
    endcase
    return r[15:0];
  endfunction

  // Transaction-level model state, one slot per DUT (0 = round-robin, 1 = fixed).
  bit          m_inflight [2];
  int          m_age      [2];
  bit          m_last     [2];
  logic [15:0] m_data     [2];
  bit          m_id       [2];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs [12];
    int   g_rr [$];
    int   id_rr [$];
    int   fp0, fp1;
    logic [15:0] bp_exp;

    drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b0, 16'h0, 4'h0, 2'b00);
    set_ready(1'b0);

    // ---- reset state ----
    #2;
    check("rst_rsp_valid", 32'(ia.rsp_valid), 0);
    check("rst_busy",      32'(busy_a), 0);
    check("rst_rsp_data",  32'(ia.rsp_data), 0);
    check("rst_rsp_id",    32'(ia.rsp_id), 0);
    check("rst_fp_busy",   32'(busy_b), 0);

    // ---- vector table ----
    vecs[0]  = '{16'h8001, 4'd1,  2'b10, 1'b0, 16'hC000};
    vecs[1]  = '{16'hB3C5, 4'd4,  2'b00, 1'b1, 16'h3C50};
    vecs[2]  = '{16'hB3C5, 4'd4,  2'b01, 1'b0, 16'h0B3C};
    vecs[3]  = '{16'hB3C5, 4'd4,  2'b10, 1'b1, 16'hFB3C};
    vecs[4]  = '{16'hB3C5, 4'd4,  2'b11, 1'b0, 16'h5B3C};
    vecs[5]  = '{16'hB3C5, 4'd0,  2'b00, 1'b1, 16'hB3C5};
    vecs[6]  = '{16'hB3C5, 4'd0,  2'b01, 1'b0, 16'hB3C5};
    vecs[7]  = '{16'hB3C5, 4'd0,  2'b10, 1'b1, 16'hB3C5};
    vecs[8]  = '{16'hB3C5, 4'd0,  2'b11, 1'b0, 16'hB3C5};
    vecs[9]  = '{16'h8001, 4'd15, 2'b11, 1'b1, 16'h0003};
    vecs[10] = '{16'hFFFF, 4'd15, 2'b00, 1'b0, 16'h8000};
    vecs[11] = '{16'h7FFF, 4'd15, 2'b10, 1'b1, 16'h0000};

    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(!vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].op, vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].op);
      set_ready(1'b1);
      #1;
      check("tab_ready_sel",   32'(vecs[k].id ? ia.req1_ready : ia.req0_ready), 1);
      check("tab_ready_other", 32'(vecs[k].id ? ia.req0_ready : ia.req1_ready), 0);
      check("tab_fp_ready",    32'(vecs[k].id ? ib.req1_ready : ib.req0_ready), 1);
      // EXEC: changing requester inputs must not disturb the in-flight op
      @(negedge clk);
      drive(1'b1, ~vecs[k].a, ~vecs[k].b, vecs[k].op + 2'd1, 1'b1, ~vecs[k].a, ~vecs[k].b, vecs[k].op + 2'd1);
      #1;
      check("tab_exec_valid", 32'(ia.rsp_valid), 0);
      check("tab_exec_ready", 32'(ia.req0_ready | ia.req1_ready), 0);
      check("tab_exec_busy",  32'(busy_a), 1);
      @(negedge clk);
      #1;
      check("tab_rsp_valid", 32'(ia.rsp_valid), 1);
      check("tab_rsp_data",  32'(ia.rsp_data), 32'(vecs[k].exp));
      check("tab_rsp_id",    32'(ia.rsp_id), 32'(vecs[k].id));
      check("tab_fp_data",   32'(ib.rsp_data), 32'(vecs[k].exp));
      check("tab_rsp_ready", 32'(ia.req0_ready | ia.req1_ready), 0);
      @(negedge clk);
      drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b0, 16'h0, 4'h0, 2'b00);
      #1;
      check("tab_idle_busy",  32'(busy_a), 0);
      check("tab_idle_valid", 32'(ia.rsp_valid), 0);
    end

    // ---- contention: both valid continuously after reset ----
    do_reset();
    set_ready(1'b1);
    fp0 = 0;
    fp1 = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      drive(1'b1, 16'h00F0 + 16'(c), 4'd1, 2'b00, 1'b1, 16'h0F00 + 16'(c), 4'd2, 2'b01);
      #1;
      if (ia.req0_ready) g_rr.push_back(0);
      if (ia.req1_ready) g_rr.push_back(1);
      if (ia.rsp_valid) id_rr.push_back(int'(ia.rsp_id));
      if (ib.req0_ready) fp0++;
      if (ib.req1_ready) fp1++;
    end
    check("rr_grant_count", 32'(g_rr.size()), 5);
    for (int k = 0; k < 4; k++) begin
      check("rr_grant_order", (k < g_rr.size()) ? 32'(g_rr[k]) : 32'hEE, 32'(k % 2));
      check("rr_rsp_id_order", (k < id_rr.size()) ? 32'(id_rr[k]) : 32'hEE, 32'(k % 2));
    end
    check("fp_grant0_count", 32'(fp0), 5);
    check("fp_grant1_count", 32'(fp1), 0);

    // ---- backpressure ----
    do_reset();
    set_ready(1'b0);
    bp_exp = ref_shift(16'h1234, 4'd3, 2'b11);
    @(negedge clk);
    drive(1'b1, 16'h1234, 4'd3, 2'b11, 1'b0, 16'h0, 4'h0, 2'b00);
    #1;
    check("bp_accept", 32'(ia.req0_ready), 1);
    @(negedge clk);
    drive(1'b1, 16'hAAAA, 4'd7, 2'b00, 1'b1, 16'h5555, 4'd9, 2'b01);
    #1;
    check("bp_exec_valid", 32'(ia.rsp_valid), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", 32'(ia.rsp_valid), 1);
      check("bp_hold_data",  32'(ia.rsp_data), 32'(bp_exp));
      check("bp_hold_id",    32'(ia.rsp_id), 0);
      check("bp_hold_ready", 32'(ia.req0_ready | ia.req1_ready), 0);
      check("bp_hold_busy",  32'(busy_a), 1);
    end
    @(negedge clk);
    set_ready(1'b1);
    #1;
    check("bp_take_valid", 32'(ia.rsp_valid), 1);
    @(negedge clk);
    #1;
    check("bp_after_busy",   32'(busy_a), 0);
    check("bp_after_rr_win", 32'(ia.req1_ready), 1);
    check("bp_after_fp_win", 32'(ib.req0_ready), 1);

    // ---- reset during EXEC ----
    do_reset();
    set_ready(1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, 16'hFFFF, 4'd4, 2'b01);
    #1;
    check("mid_accept", 32'(ia.req1_ready), 1);
    @(negedge clk);
    drive(1'b0, 16'h0, 4'h0, 2'b00, 1'b0, 16'h0, 4'h0, 2'b00);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(busy_a), 0);
    check("mid_rst_valid", 32'(ia.rsp_valid), 0);
    check("mid_rst_data",  32'(ia.rsp_data), 0);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("mid_no_stale_valid", 32'(ia.rsp_valid), 0);
      check("mid_no_stale_busy",  32'(busy_a), 0);
    end

    // ---- randomized traffic against the reference model ----
    do_reset();
    for (int m = 0; m < 2; m++) begin
      m_inflight[m] = 1'b0;
      m_age[m]      = 0;
      m_last[m]     = 1'b1;
      m_data[m]     = 16'h0;
      m_id[m]       = 1'b0;
    end
    for (int c = 0; c < 800; c++) begin
      logic v0, v1, rr, w, can, exp_v;
      logic [15:0] a0, a1;
      logic [3:0]  b0, b1;
      logic [1:0]  o0, o1;
      logic        act_r0, act_r1, act_v, act_busy, act_id;
      logic [15:0] act_d;
      @(negedge clk);
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a0 = 16'($urandom); a1 = 16'($urandom);
      b0 = 4'($urandom);  b1 = 4'($urandom);
      o0 = 2'($urandom);  o1 = 2'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      drive(v0, a0, b0, o0, v1, a1, b1, o1);
      set_ready(rr);
      #1;
      for (int m = 0; m < 2; m++) begin
        act_r0   = (m == 0) ? ia.req0_ready : ib.req0_ready;
        act_r1   = (m == 0) ? ia.req1_ready : ib.req1_ready;
        act_v    = (m == 0) ? ia.rsp_valid  : ib.rsp_valid;
        act_d    = (m == 0) ? ia.rsp_data   : ib.rsp_data;
        act_id   = (m == 0) ? ia.rsp_id     : ib.rsp_id;
        act_busy = (m == 0) ? busy_a        : busy_b;
        if (v0 && v1) w = (m == 0) ? !m_last[m] : 1'b0;
        else          w = v1;
        can   = !m_inflight[m] && (v0 || v1);
        exp_v = m_inflight[m] && (m_age[m] >= 2);
        check("rnd_ready0", 32'(act_r0), 32'(can && !w));
        check("rnd_ready1", 32'(act_r1), 32'(can && w));
        check("rnd_busy",   32'(act_busy), 32'(m_inflight[m]));
        check("rnd_valid",  32'(act_v), 32'(exp_v));
        if (exp_v) begin
          check("rnd_data", 32'(act_d), 32'(m_data[m]));
          check("rnd_id",   32'(act_id), 32'(m_id[m]));
        end
        if (can) begin
          m_inflight[m] = 1'b1;
          m_age[m]      = 1;
          m_data[m]     = w ? ref_shift(a1, b1, o1) : ref_shift(a0, b0, o0);
          m_id[m]       = w;
          m_last[m]     = w;
        end else if (m_inflight[m]) begin
          if (m_age[m] >= 2) begin
            if (rr) m_inflight[m] = 1'b0;
          end else begin
            m_age[m] = m_age[m] + 1;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, data width of operand and result; only 16 is supported.
REQ-002 Parameter: RR_EN, 1, 1 selects round-robin arbitration, 0 selects fixed priority with requester 0 highest.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-006 req0_ready / req1_ready  output  1  requester i's operation is accepted this cycle.
REQ-007 req0_a / req1_a  input  16  operand.
REQ-008 req0_b / req1_b  input  4  shift amount, 0-15.
REQ-009 req0_op / req1_op  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer takes the result.
REQ-012 rsp_data  output  16  shifted result.
REQ-013 rsp_id  output  1  index of the requester that issued the result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states are IDLE, EXEC and RESP; the state register is 2 bits.
- IDLE -> EXEC on accept.
- EXEC -> RESP unconditionally.
- RESP -> IDLE when rsp_ready=1.
- The FSM otherwise holds its state.
REQ-016 Request acceptance:
- Accept occurs only in IDLE.
- At most one reqX_ready is high per cycle.
- reqX_ready is combinational: high only if IDLE and reqX_valid and requester X wins arbitration.
REQ-017 On accept, the FSM latches a, b, op and the winner id into operand registers.
REQ-018 Arbitration when RR_EN=1:
- One-bit last_grant register.
- When both are valid, the requester not equal to last_grant wins.
- A lone valid requester always wins.
- last_grant updates to the winner on each accept.
REQ-019 When RR_EN=0 and both requesters are valid, requester 0 always wins.
REQ-020 In EXEC, the result is computed from the latched operands and registered into rsp_data:
- LSL = a << b, zero fill.
- LSR = a >> b, zero fill.
- ASR = a >> b, every vacated bit filled with a[15].
- ROR = rotate right by b.
- b=0 returns a unchanged for all ops.
REQ-021 In RESP:
- rsp_valid=1.
- rsp_data and rsp_id stay stable until the cycle rsp_ready=1 is sampled.
REQ-022 Latency is fixed. If accept occurs in cycle N, then rsp_valid=1 first in cycle N+2.
REQ-023 Throughput is at most one accept per 3 cycles.
REQ-024 A rsp_ready=1 sampled in IDLE or EXEC has no effect.
REQ-025 Requester inputs that change while the FSM is in EXEC or RESP do not affect the in-flight result.
REQ-026 Deassertion of reqX_valid with no accept leaves the arbiter and last_grant unchanged.

Reset
REQ-027 While rst_n=0, asynchronously:
- state=IDLE.
- rsp_valid=0, busy=0, rsp_data=16'h0000, rsp_id=0.
- last_grant=1, so requester 0 wins the first contention.
- Operand registers are cleared.
REQ-028 Asserting reset in EXEC or RESP discards the in-flight operation.
- No response is produced for it after release.
REQ-029 After rst_n deasserts, the first accept can occur on the first rising edge where a request is valid.

Verification
REQ-030 Single request: req0 a=16'h8001, b=1, op=ASR -> req0_ready high 1 cycle; 2 cycles later rsp_valid=1, rsp_data=16'hC000, rsp_id=0.
REQ-031 Op sweep: a=16'hB3C5, b=4 -> LSL 16'h3C50, LSR 16'h0B3C, ASR 16'hFB3C, ROR 16'h5B3C. Also b=0 returns 16'hB3C5 for every op.
REQ-032 Contention with RR_EN=1: both requesters valid continuously after reset -> grants alternate 0,1,0,1 and rsp_id follows the same order.
REQ-033 Contention with RR_EN=0: both valid continuously -> every grant goes to requester 0 and req1_ready stays 0.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_id stable, no req*_ready asserted, busy=1; with rsp_ready=1, RESP->IDLE next cycle.
REQ-035 Reset mid-operation: rst_n pulsed low during EXEC -> rsp_valid stays 0, state IDLE, and no stale response appears after release.
